mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access stage between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns a load or store from EX/MEM into a req/ack transaction on a variable-latency data-memory port. It stalls the pipeline until the access completes and presents the load data and the passthrough ALU address to MEM/WB.

## Interface
- No parameters; data and address widths are fixed at 32 bits.
- clk_i  in  1  pipeline clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  CPU run enable; when low, no new access is accepted.
- MemRead_i  in  1  EX/MEM load control.
- MemWrite_i  in  1  EX/MEM store control.
- Addr_i  in  32  EX/MEM ALU result (byte address).
- WriteData_i  in  32  EX/MEM store data.
- MemAddr_o  out  32  Addr_i passthrough to MEM/WB (combinational).
- MemRead_Data_o  out  32  load data to MEM/WB.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble-free hold.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o = 1.
- mem_addr_o  out  32  word address {addr[31:2],2'b00}, held while mem_req_o = 1.
- mem_wdata_o  out  32  write data, held while mem_req_o = 1.
- mem_ack_i  in  1  one-cycle completion pulse from memory.
- mem_rdata_i  in  32  read data, valid in the mem_ack_i cycle.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if start_i=1 and MemRead_i or MemWrite_i is set, latch address, data and direction, then go to BUSY. stall_o=1 in that cycle.
- MemRead_i and MemWrite_i both high: the access is a read; the write is dropped.
- BUSY: mem_req_o=1 and stall_o=1. On mem_ack_i=1, capture mem_rdata_i into the load register if the access is a read, then go to DONE.
- DONE: stall_o=0, mem_req_o=0, MemRead_Data_o = captured data. MEM/WB samples on this edge and EX/MEM advances. Always returns to IDLE; never accepts a new access.
- MemRead_Data_o holds its last captured value until the next read completes. Stores do not change it.
- mem_ack_i outside BUSY is ignored.
- start_i low: no new access starts and stall_o=0 in IDLE. An access already in BUSY runs to completion.
- Reset (async, any state): state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, MemRead_Data_o=0, stall_o=0. An in-flight or buffered access is abandoned.

## Timing
- mem_req_o rises on the edge after acceptance. The memory may ack in the first req cycle or later.
- Ack in first req cycle: stall_o is high for 2 cycles, then DONE. The instruction occupies the stage for 3 cycles.
- Each extra ack wait cycle adds exactly one stall cycle.
- mem_req_o falls on the edge after mem_ack_i.

## Configuration
- DMEM_STORE_BUFFER_EN defined: adds a one-entry posted write buffer.
  - A store in IDLE with the buffer empty is captured in the buffer with no stall; the stage completes in 1 cycle.
  - The buffer drains through the memory port: mem_req_o rises on the next edge and the entry is freed on ack.
  - A load or a second store arriving while the buffer is occupied stalls until the drain ack, then proceeds normally.
  - No load forwarding from the buffer is performed.
  - Reset clears the buffer.
- Undefined: every store takes the blocking IDLE→BUSY→DONE path.

## Test plan
- Load, Addr_i=0x00000104, ack in first req cycle, mem_rdata_i=0xDEADBEEF:
  - mem_addr_o=0x00000104, mem_we_o=0.
  - stall_o is high for exactly 2 cycles.
  - MemRead_Data_o=0xDEADBEEF in DONE.
- Store, Addr_i=0x22, WriteData_i=0x12345678, ack after 3 wait cycles, macro off:
  - mem_addr_o=0x20, mem_wdata_o=0x12345678, mem_we_o=1.
  - stall_o is high for 5 cycles.
  - MemRead_Data_o is unchanged.
- Back-to-back loads from 0x10 and 0x14:
  - Two separate transactions, each with one DONE cycle.
  - The second request starts only after returning to IDLE.
- rst_i pulsed low while in BUSY:
  - mem_req_o and stall_o drop immediately.
  - A late mem_ack_i after reset is ignored and MemRead_Data_o stays 0.
- MemRead_i=MemWrite_i=1:
  - mem_we_o=0 and a read is performed.
- With DMEM_STORE_BUFFER_EN, store then load, ack latency 2:
  - The store has no stall.
  - The load stalls until the drain ack, then completes its own read.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory access stage: turns an EX/MEM load/store into a req/ack transaction and stalls until it completes.
// Optional one-entry posted store buffer is enabled by defining DMEM_STORE_BUFFER_EN.
module mem_access_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] MemAddr_o,
  output logic [31:0] MemRead_Data_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, stateNext;

  logic accessReq;
  logic isWrite;
  logic acceptBlk;
  logic postStore;
  logic ackTake;
  logic bufValid;
  logic postOk;
  logic drainAck;

  function automatic logic [31:0] wordAddr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  assign MemAddr_o = Addr_i;
  assign accessReq = start_i & (MemRead_i | MemWrite_i);
  // A simultaneous read and write request is treated as a read.
  assign isWrite   = MemWrite_i & ~MemRead_i;

`ifdef DMEM_STORE_BUFFER_EN
  // Buffer only ever fills from IDLE and blocks new accesses, so the drain
  // always completes while the FSM sits in IDLE.
  assign postOk   = isWrite & ~bufValid;
  assign drainAck = bufValid & mem_ack_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bufValid <= 1'b0;
    end else if (postStore) begin
      bufValid <= 1'b1;
    end else if (drainAck) begin
      bufValid <= 1'b0;
    end
  end
`else
  assign bufValid = 1'b0;
  assign postOk   = 1'b0;
  assign drainAck = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    stall_o   = 1'b0;
    acceptBlk = 1'b0;
    postStore = 1'b0;
    ackTake   = 1'b0;
    case (state)
      IDLE: begin
        if (accessReq) begin
          if (postOk) begin
            postStore = 1'b1;
          end else if (bufValid) begin
            stall_o = 1'b1;
          end else begin
            acceptBlk = 1'b1;
            stall_o   = 1'b1;
            stateNext = BUSY;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          ackTake   = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Memory port registers: loaded on acceptance, request dropped on the completing ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
    end else if (acceptBlk || postStore) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= isWrite;
      mem_addr_o  <= wordAddr(Addr_i);
      mem_wdata_o <= WriteData_i;
    end else if (ackTake || drainAck) begin
      mem_req_o   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      MemRead_Data_o <= 32'h0;
    end else if (ackTake && !mem_we_o) begin
      MemRead_Data_o <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; store-buffer scenario built when DMEM_STORE_BUFFER_EN is defined.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] Addr_i;
  logic [31:0] WriteData_i;
  logic [31:0] MemAddr_o;
  logic [31:0] MemRead_Data_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  mem_access_unit dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .MemRead_i      (MemRead_i),
    .MemWrite_i     (MemWrite_i),
    .Addr_i         (Addr_i),
    .WriteData_i    (WriteData_i),
    .MemAddr_o      (MemAddr_o),
    .MemRead_Data_o (MemRead_Data_o),
    .stall_o        (stall_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drives one instruction from IDLE until the stage releases the stall, acking the
  // memory after 'waits' extra request cycles.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                           output int stalls, output int reqCycles, output logic [31:0] seenAddr,
                           output logic [31:0] seenWdata, output logic seenWe,
                           output logic [31:0] doneData, output logic reqAtDone, output bit timedOut);
    int waitCnt = 0;
    int cyc = 0;
    bit done = 0;
    stalls = 0; reqCycles = 0; seenAddr = 'x; seenWdata = 'x; seenWe = 1'bx;
    doneData = 'x; reqAtDone = 1'bx; timedOut = 0;
    start_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; Addr_i = addr; WriteData_i = wdata;
    while (!done && !timedOut) begin
      #1;
      if (mem_req_o) begin
        reqCycles++;
        seenAddr = mem_addr_o; seenWdata = mem_wdata_o; seenWe = mem_we_o;
        if (waitCnt == waits) begin
          mem_ack_i = 1'b1; mem_rdata_i = rdata;
        end else begin
          waitCnt++;
        end
      end
      if (stall_o) begin
        stalls++;
      end else begin
        done = 1; doneData = MemRead_Data_o; reqAtDone = mem_req_o;
      end
      step();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      cyc++;
      if (cyc > 40) timedOut = 1;
    end
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    Addr_i = 32'h0; WriteData_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    step(); step();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", mem_req_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", mem_we_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
    checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata_o); end
    checks++; if (MemRead_Data_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", MemRead_Data_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_load();
    int s, r; logic [31:0] a, w, d; logic we, rq; bit to;
    Addr_i = 32'h0000_0104;
    #1;
    checks++; if (MemAddr_o !== 32'h0000_0104) begin errors++; $display("FAIL load_passthru got=%h exp=00000104", MemAddr_o); end
    do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, 32'hDEAD_BEEF, s, r, a, w, we, d, rq, to);
    checks++; if (to) begin errors++; $display("FAIL load_timeout got=timeout exp=done"); end
    checks++; if (a !== 32'h0000_0104) begin errors++; $display("FAIL load_addr got=%h exp=00000104", a); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL load_we got=%b exp=0", we); end
    checks++; if (s !== 2) begin errors++; $display("FAIL load_stall got=%0d exp=2", s); end
    checks++; if (r !== 1) begin errors++; $display("FAIL load_reqcycles got=%0d exp=1", r); end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data got=%h exp=deadbeef", d); end
    checks++; if (rq !== 1'b0) begin errors++; $display("FAIL load_req_done got=%b exp=0", rq); end
  endtask

  task automatic test_store();
    int s, r; logic [31:0] a, w, d; logic we, rq; bit to;
    do_access(1'b0, 1'b1, 32'h0000_0022, 32'h1234_5678, 3, 32'hFFFF_0000, s, r, a, w, we, d, rq, to);
    checks++; if (to) begin errors++; $display("FAIL store_timeout got=timeout exp=done"); end
    checks++; if (a !== 32'h0000_0020) begin errors++; $display("FAIL store_addr got=%h exp=00000020", a); end
    checks++; if (w !== 32'h1234_5678) begin errors++; $display("FAIL store_wdata got=%h exp=12345678", w); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL store_we got=%b exp=1", we); end
    checks++; if (s !== 5) begin errors++; $display("FAIL store_stall got=%0d exp=5", s); end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_rdata_kept got=%h exp=deadbeef", d); end
  endtask

  task automatic test_back_to_back();
    int s1, r1, s2, r2; logic [31:0] a1, a2, w, d1, d2; logic we, rq1, rq2; bit to1, to2;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h1111_0010, s1, r1, a1, w, we, d1, rq1, to1);
    do_access(1'b1, 1'b0, 32'h14, 32'h0, 1, 32'h2222_0014, s2, r2, a2, w, we, d2, rq2, to2);
    checks++; if (to1 || to2) begin errors++; $display("FAIL b2b_timeout got=%0d/%0d exp=0/0", to1, to2); end
    checks++; if (a1 !== 32'h10 || a2 !== 32'h14) begin errors++; $display("FAIL b2b_addr got=%h/%h exp=10/14", a1, a2); end
    checks++; if (s1 !== 2 || s2 !== 3) begin errors++; $display("FAIL b2b_stall got=%0d/%0d exp=2/3", s1, s2); end
    checks++; if (d1 !== 32'h1111_0010 || d2 !== 32'h2222_0014) begin errors++; $display("FAIL b2b_data got=%h/%h exp=11110010/22220014", d1, d2); end
    checks++; if (rq1 !== 1'b0 || rq2 !== 1'b0) begin errors++; $display("FAIL b2b_req_done got=%b/%b exp=0/0", rq1, rq2); end
  endtask

  task automatic test_both_high();
    int s, r; logic [31:0] a, w, d; logic we, rq; bit to;
    do_access(1'b1, 1'b1, 32'h33, 32'hFFFF_FFFF, 0, 32'hCAFE_F00D, s, r, a, w, we, d, rq, to);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL both_we got=%b exp=0", we); end
    checks++; if (a !== 32'h30) begin errors++; $display("FAIL both_addr got=%h exp=00000030", a); end
    checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL both_data got=%h exp=cafef00d", d); end
  endtask

  task automatic test_start_low();
    start_i = 1'b0; MemRead_i = 1'b1; Addr_i = 32'h80;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL startlow_stall got=%b exp=0", stall_o); end
    step();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL startlow_req got=%b exp=0", mem_req_o); end
    MemRead_i = 1'b0; start_i = 1'b1;
  endtask

  task automatic test_ack_ignored();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    step();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    checks++; if (MemRead_Data_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL ackidle_data got=%h exp=cafef00d", MemRead_Data_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL ackidle_req got=%b exp=0", mem_req_o); end
  endtask

  task automatic test_reset_busy();
    start_i = 1'b1; MemRead_i = 1'b1; Addr_i = 32'h200;
    step();
    checks++; if (mem_req_o !== 1'b1 || stall_o !== 1'b1) begin errors++; $display("FAIL rstbusy_pre got=%b%b exp=11", mem_req_o, stall_o); end
    rst_i = 1'b0; MemRead_i = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL rstbusy_drop got=%b%b exp=00", mem_req_o, stall_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    step();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    checks++; if (MemRead_Data_o !== 32'h0) begin errors++; $display("FAIL rstbusy_lateack got=%h exp=0", MemRead_Data_o); end
    checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL rstbusy_after got=%b%b exp=00", mem_req_o, stall_o); end
  endtask

`ifdef DMEM_STORE_BUFFER_EN
  task automatic test_store_buffer();
    int s, r; logic [31:0] a, w, d; logic we, rq; bit to;
    start_i = 1'b1; MemWrite_i = 1'b1; MemRead_i = 1'b0; Addr_i = 32'h41; WriteData_i = 32'hA5A5_A5A5;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL sb_store_stall got=%b exp=0", stall_o); end
    step();
    MemWrite_i = 1'b0; MemRead_i = 1'b1; Addr_i = 32'h44;
    #1;
    checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h40 || mem_wdata_o !== 32'hA5A5_A5A5)
      begin errors++; $display("FAIL sb_drain got=%b%b %h %h exp=11 00000040 a5a5a5a5", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL sb_load_wait1 got=%b exp=1", stall_o); end
    step();
    mem_ack_i = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL sb_load_wait2 got=%b exp=1", stall_o); end
    step();
    mem_ack_i = 1'b0;
    do_access(1'b1, 1'b0, 32'h44, 32'h0, 1, 32'h5A5A_0044, s, r, a, w, we, d, rq, to);
    checks++; if (s !== 3 || we !== 1'b0 || a !== 32'h44) begin errors++; $display("FAIL sb_load got=%0d %b %h exp=3 0 00000044", s, we, a); end
    checks++; if (d !== 32'h5A5A_0044) begin errors++; $display("FAIL sb_load_data got=%h exp=5a5a0044", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
`ifndef DMEM_STORE_BUFFER_EN
    test_store();
`endif
    test_back_to_back();
    test_both_high();
    test_start_low();
    test_ack_ignored();
    test_reset_busy();
`ifdef DMEM_STORE_BUFFER_EN
    test_store_buffer();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
